// File: rtl/ysyx_24070014_lsu_pkg.sv
// Shared definitions for the LSU: FSM states, funct3 codes and op legality helpers.
package ysyx_24070014_lsu_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} lsu_state_e;

    localparam int unsigned OpStoreBit = 3;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    // op = {is_store, funct3}; stores have no unsigned variants
    function automatic logic op_legal(input logic [3:0] op);
        if (op[OpStoreBit]) begin
            return op[2:0] inside {F3Byte, F3Half, F3Word};
        end
        return op[2:0] inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU};
    endfunction

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24070014_lsu_align.sv
// Byte-lane steering: store mask/data placement and load extract with sign/zero extension.
module ysyx_24070014_lsu_align
    import ysyx_24070014_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rdata_shifted;

    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = 32'h0;
        case (funct3_i[1:0])
            2'b00: begin
                wmask_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                wmask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                wmask_o = 4'b1111;
                wdata_o = wdata_i;
            end
            default: ;
        endcase
    end

    assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3Byte:  rdata_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            F3Half:  rdata_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            F3Word:  rdata_o = rdata_i;
            F3ByteU: rdata_o = {24'h0, rdata_shifted[7:0]};
            F3HalfU: rdata_o = {16'h0, rdata_shifted[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/ysyx_24070014_lsu.sv
// RV32 load/store unit: one blocking access at a time over a valid/ready memory bus.
module ysyx_24070014_lsu
    import ysyx_24070014_lsu_pkg::*;
#(
    parameter int unsigned WORD_LEN = 32,
    parameter int unsigned ADDR_LEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic [WORD_LEN-1:0] req_wdata_i,
    input  logic [3:0]          req_op_i,
    output logic                rsp_valid_o,
    output logic [WORD_LEN-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic                mem_wen_o,
    output logic [3:0]          mem_wmask_o,
    output logic [WORD_LEN-1:0] mem_wdata_o,
    input  logic                mem_rsp_valid_i,
    input  logic [WORD_LEN-1:0] mem_rdata_i
);

    lsu_state_e          state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic [WORD_LEN-1:0] rdata_q, rdata_d;
    logic [3:0]          op_q, op_d;
    logic                err_q, err_d;

    logic [3:0]          lane_wmask;
    logic [WORD_LEN-1:0] lane_wdata;
    logic [WORD_LEN-1:0] load_data;

    ysyx_24070014_lsu_align u_align (
        .funct3_i  (op_q[2:0]),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (rdata_q),
        .wmask_o   (lane_wmask),
        .wdata_o   (lane_wdata),
        .rdata_o   (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    op_d    = req_op_i;
                    err_d   = !op_legal(req_op_i) ||
                              addr_misaligned(req_op_i[1:0], req_addr_i[1:0]);
                    // Faulting accesses never touch the bus.
                    state_d = err_d ? StResp : StReq;
                end
            end
            StReq: begin
                if (mem_req_ready_i) state_d = StWait;
            end
            StWait: begin
                if (mem_rsp_valid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o     = 1'b0;
        rsp_valid_o     = 1'b0;
        rsp_data_o      = '0;
        rsp_err_o       = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_addr_o      = '0;
        mem_wen_o       = 1'b0;
        mem_wmask_o     = 4'b0000;
        mem_wdata_o     = '0;
        unique case (state_q)
            StIdle: req_ready_o = 1'b1;
            StReq: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = {addr_q[ADDR_LEN-1:2], 2'b00};
                mem_wen_o       = op_q[OpStoreBit];
                mem_wmask_o     = op_q[OpStoreBit] ? lane_wmask : 4'b0000;
                mem_wdata_o     = op_q[OpStoreBit] ? lane_wdata : '0;
            end
            StWait: ;
            StResp: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                rsp_data_o  = (err_q || op_q[OpStoreBit]) ? '0 : load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// Randomised bench for the LSU with a behavioural access model and a reactive memory driver.
module tb_ysyx_24070014_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    ysyx_24070014_lsu #(.WORD_LEN(32), .ADDR_LEN(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_op_i        (req_op),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .rsp_err_o       (rsp_err),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_addr_o      (mem_addr),
        .mem_wen_o       (mem_wen),
        .mem_wmask_o     (mem_wmask),
        .mem_wdata_o     (mem_wdata),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rdata_i     (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one access and act as memory; ready after rdy_dly request cycles,
    // response after rsp_dly wait cycles.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] op,
                          input logic [31:0] rd, input int rdy_dly, input int rsp_dly);
        logic        st;
        logic [2:0]  f3;
        logic        legal;
        logic        exp_err;
        int          size;
        int          lane;
        logic [31:0] bval;
        logic [31:0] hval;
        logic [31:0] exp_data;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wd;
        int          exp_lat;
        int          lat;
        int          req_cnt;
        int          w;
        logic        hs;
        logic        got;

        st    = op[3];
        f3    = op[2:0];
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        exp_err = !legal || ((addr % size) != 0);
        lane  = int'(addr[1:0]);
        bval  = (rd >> (8 * lane)) & 32'hFF;
        hval  = (rd >> (8 * lane)) & 32'hFFFF;
        case (f3)
            3'd0:    exp_data = (bval >= 128) ? bval - 32'd256 : bval;
            3'd1:    exp_data = (hval >= 32768) ? hval - 32'h10000 : hval;
            3'd2:    exp_data = rd;
            3'd4:    exp_data = bval;
            default: exp_data = hval;
        endcase
        if (st || exp_err) exp_data = 32'h0;
        exp_mask = 4'b0000;
        exp_wd   = 32'h0;
        if (st) begin
            case (f3)
                3'd0: begin exp_mask = 4'b0001 << lane; exp_wd = (wd & 32'hFF) * 32'h01010101; end
                3'd1: begin exp_mask = 4'b0011 << lane; exp_wd = (wd & 32'hFFFF) * 32'h00010001; end
                default: begin exp_mask = 4'b1111; exp_wd = wd; end
            endcase
        end
        exp_lat = exp_err ? 1 : rdy_dly + rsp_dly + 3;

        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wdata = wd;
        req_op    = op;
        hs = 1'b0; got = 1'b0; req_cnt = 0; w = 0; lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            req_addr      = $urandom;
            req_wdata     = $urandom;
            req_op        = 4'($urandom);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            if (rsp_valid) begin
                lat = c;
                got = 1'b1;
                break;
            end
            if (mem_req_valid) begin
                check("req_when_err", {31'h0, mem_req_valid}, {31'h0, !exp_err});
                check("req_after_hs", {31'h0, hs}, 32'h0);
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_wen", {31'h0, mem_wen}, {31'h0, st});
                check("mem_wmask", {28'h0, mem_wmask}, {28'h0, exp_mask});
                check("mem_wdata", mem_wdata, exp_wd);
                req_cnt++;
                if (req_cnt > rdy_dly) begin
                    mem_req_ready = 1'b1;
                    hs = 1'b1;
                end
                // Stray response during the request phase must be ignored.
                mem_rsp_valid = 1'($urandom_range(0, 1));
            end else if (hs) begin
                if (w == rsp_dly) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rd;
                end
                w++;
            end
        end
        if (!got) begin
            check("rsp_timeout", 32'h0, 32'h1);
            return;
        end
        check("latency", lat, exp_lat);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
        check("rsp_data", rsp_data, exp_data);
        last_data = rsp_data;
        @(negedge clk);
        check("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
        check("ready_after", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_op = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        last_data = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req_valid}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
        check("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        do_txn(32'h8000_0004, 32'h0, 4'b0010, 32'hDEAD_BEEF, 0, 0);
        check("lw_const", last_data, 32'hDEAD_BEEF);
        do_txn(32'h8000_0003, 32'h0, 4'b0000, 32'h8012_3456, 0, 0);
        check("lb_const", last_data, 32'hFFFF_FF80);
        do_txn(32'h8000_0003, 32'h0, 4'b0100, 32'h8012_3456, 0, 0);
        check("lbu_const", last_data, 32'h0000_0080);
        do_txn(32'h8000_0002, 32'h0000_ABCD, 4'b1001, 32'h0, 0, 0);
        do_txn(32'h8000_0002, 32'h0, 4'b0010, 32'h1234_5678, 0, 0);
        do_txn(32'h8000_0008, 32'h0, 4'b0010, 32'hCAFE_F00D, 5, 3);
        do_txn(32'h8000_0001, 32'h0, 4'b0111, 32'h0, 0, 0);

        // Reset while waiting for the memory response.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_op = 4'b0010;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw_req", {31'h0, mem_req_valid}, 32'h1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstw_wait", {31'h0, mem_req_valid}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_ready", {31'h0, req_ready}, 32'h1);
        check("rstw_memreq", {31'h0, mem_req_valid}, 32'h0);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        repeat (3) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            check("rstw_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        do_txn(32'h8000_0010, 32'h0, 4'b0010, 32'h0BAD_CAFE, 1, 1);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
